bcrypt_axis8_outpkt_fifo: RTL and testbench
===========================================

// Module: bcrypt_axis8_outpkt_fifo
// PURPOSE
//  Store-and-forward packet FIFO on the 8-bit AXIS result stream of the bcrypt wrapper.
//  Sits between the wrapper's m_axis output and the LiteX DMA/CSR reader.
//  Releases a packet downstream only once its TLAST byte has been stored, so the host never stalls mid-packet.
//  Exposes packet and byte occupancy and overflow status for CSRs.
// PARAMETERS
//  DEPTH     1024  byte storage entries; power of 2, >=16; each entry is {last,data[7:0]}
//  MAX_PKTS  16    maximum number of complete packets held at once
// PORTS
//  CORE_CLK       in   1              single clock
//  CORE_RSTN      in   1              reset, asynchronous assert, active-low
//  flush          in   1              synchronous clear of all contents
//  s_axis_tdata   in   8              input byte from the wrapper
//  s_axis_tvalid  in   1              input valid
//  s_axis_tready  out  1              input ready
//  s_axis_tlast   in   1              last byte of the input packet
//  m_axis_tdata   out  8              output byte
//  m_axis_tvalid  out  1              output valid
//  m_axis_tready  in   1              output ready
//  m_axis_tlast   out  1              last byte of the output packet
//  pkt_count      out  clog2(MAX_PKTS)+1  complete packets stored, including the one currently streaming
//  level          out  clog2(DEPTH)+1     bytes stored, complete plus partial
//  overflow       out  1              sticky; set when a packet is dropped
//  drop_count     out  8              count of dropped packets; saturates at 255
// BEHAVIOUR
//  Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_count=0,
//   level=0, overflow=0, drop_count=0.
//  After reset release: s_axis_tready is 1 from the first clock edge onward while space is available.
//  Input FSM, two states: ACCEPT and DROP.
//  - ACCEPT: s_axis_tready = (level<DEPTH) & (pkt_count<MAX_PKTS) & ~flush.
//    Each handshake writes {tlast,tdata}, increments wr_ptr, and increments cur_len.
//    A handshake with tlast=1 commits the packet: pkt_count+1 and pkt_start<=wr_ptr+1, visible the next cycle.
//    If cur_len==DEPTH before the beat and the beat has tlast=0, the packet is larger than the memory:
//    wr_ptr rewinds to pkt_start, level drops by cur_len, overflow<=1, drop_count+1, go to DROP.
//    The rewind happens in that same cycle, and that beat is discarded.
//  - DROP: s_axis_tready=1; beats are discarded. The tlast beat returns the FSM to ACCEPT, and cur_len<=0.
//  - A packet of exactly DEPTH bytes with tlast on the DEPTH-th byte is committed, not dropped.
//  Output FSM, three states: IDLE, LOAD, STREAM.
//  - IDLE goes to LOAD when pkt_count>0.
//  - LOAD: issue the synchronous memory read at rd_ptr (1-cycle read latency); go to STREAM with m_axis_tvalid=1.
//  - First-byte latency: m_axis_tvalid rises 2 cycles after pkt_count becomes nonzero.
//  - STREAM: m_axis_tdata/tlast are held stable while tvalid=1 and tready=0.
//    With tready held high the block sustains 1 byte/cycle; prefetch or skid as needed.
//    No bubbles are allowed inside a packet.
//  - The m_axis_tlast handshake decrements pkt_count. The next state is IDLE if no other packet is complete.
//    Otherwise the next packet's first byte follows with at most 1 bubble cycle.
//  - The output never presents a byte of an uncommitted packet.
//  Occupancy arithmetic:
//  - level changes by (+1 on input write) - (1 on output handshake) - (cur_len on drop); all updates apply in the same cycle.
//  - pkt_count: a simultaneous commit and output-tlast in one cycle leaves it unchanged.
//  - Pointers are clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full is level==DEPTH.
//  flush (synchronous, one cycle) clears pointers, level, pkt_count and cur_len.
//  - Input FSM goes to DROP if an input packet is mid-flight, otherwise to ACCEPT.
//  - Output FSM goes to IDLE with m_axis_tvalid=0.
//  - overflow and drop_count are NOT cleared by flush.
//  Asynchronous reset mid-packet: everything returns to its reset values, and the first byte seen afterwards starts a new packet.
// TESTING
//  1. Write 5-byte packet 01..05 (tlast on 05), tready=1.
//     -> pkt_count=1 the cycle after 05; m_axis shows 01..05 on 5 consecutive cycles, tlast only on 05;
//        then pkt_count=0, level=0.
//  2. Write 3 bytes with no tlast, m_axis_tready=1.
//     -> m_axis_tvalid stays 0 for 50 cycles and level=3; sending tlast byte 04 -> 01..04 delivered.
//  3. DEPTH=16: send a 20-byte packet, then a 2-byte packet AA,BB.
//     -> first packet dropped, overflow=1, drop_count=1, level=0 after the rewind; output is exactly AA,BB.
//  4. Fill MAX_PKTS 1-byte packets with m_axis_tready=0.
//     -> s_axis_tready=0 when pkt_count=16; one output handshake re-asserts it the next cycle.
//  5. Commit on the same cycle as an output tlast handshake -> pkt_count unchanged; byte order preserved.
//  6. m_axis_tready toggled randomly mid-packet -> tdata/tlast stable while stalled; flush mid-output
//     -> tvalid=0 next cycle, level=0, overflow kept.

Source files
------------

// File: rtl/bcrypt_axis8_outpkt_fifo.sv
// bcrypt_axis8_outpkt_fifo
//
// Store-and-forward packet FIFO on the 8-bit AXIS result stream of the bcrypt
// wrapper. A packet is only offered downstream once its TLAST byte is stored,
// so the DMA/CSR reader never stalls mid-packet. Packets larger than the
// whole memory are dropped and counted.
//
// Ports
//   CORE_CLK, CORE_RSTN      clock, asynchronous active-low reset
//   flush                    synchronous clear of stored data and pointers
//   s_axis_*                 8-bit AXIS input from the wrapper
//   m_axis_*                 8-bit AXIS output towards the reader
//   pkt_count                complete packets held, including the one streaming
//   level                    bytes held, complete plus partial
//   overflow                 sticky, set when a packet is dropped
//   drop_count               dropped packets, saturating at 255
//
// Input FSM
//   state      | meaning
//   IN_ACCEPT  | storing beats of the current packet
//   IN_DROP    | discarding beats until the tlast of a dropped/flushed packet
//
// Output FSM
//   state      | meaning
//   OUT_IDLE   | no complete packet to send
//   OUT_LOAD   | memory read of the first byte in flight
//   OUT_STREAM | out_q holds a valid byte presented on m_axis

module bcrypt_axis8_outpkt_fifo #(
    parameter int DEPTH    = 1024,
    parameter int MAX_PKTS = 16
) (
    input  logic                       CORE_CLK,
    input  logic                       CORE_RSTN,
    input  logic                       flush,
    input  logic [7:0]                 s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(MAX_PKTS):0]  pkt_count,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PKTS) + 1;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] MAX_L   = PW'(MAX_PKTS);

    typedef enum logic {IN_ACCEPT, IN_DROP} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_LOAD, OUT_STREAM} out_state_t;

    in_state_t  in_state, in_next;
    out_state_t out_state, out_next;

    logic [8:0]  mem [DEPTH];
    logic [8:0]  out_q;
    logic [AW:0] wr_ptr, rd_ptr, pkt_start, cur_len;
    logic        ready_en;

    logic in_hs, too_big, wr_en, commit;
    logic out_hs, out_last, rd_en;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    // While a packet already fills the memory (cur_len==DEPTH) the next beat
    // must still be taken so it can be recognised as oversize and dropped.
    always_comb begin
        s_axis_tready = 1'b0;
        if (ready_en) begin
            if (in_state == IN_DROP) begin
                s_axis_tready = 1'b1;
            end else begin
                s_axis_tready = ~flush & (pkt_count < MAX_L) &
                                ((level < DEPTH_L) | (cur_len == DEPTH_L));
            end
        end
    end

    assign in_hs   = s_axis_tvalid & s_axis_tready;
    assign too_big = (in_state == IN_ACCEPT) & in_hs & (cur_len == DEPTH_L);
    assign wr_en   = (in_state == IN_ACCEPT) & in_hs & ~too_big;
    assign commit  = wr_en & s_axis_tlast;

    always_comb begin
        in_next = in_state;
        if (flush) begin
            // A packet caught mid-flight is discarded up to its tlast.
            if (((in_state == IN_DROP) & ~(in_hs & s_axis_tlast)) |
                ((in_state == IN_ACCEPT) & (cur_len != '0))) begin
                in_next = IN_DROP;
            end else begin
                in_next = IN_ACCEPT;
            end
        end else if (in_state == IN_ACCEPT) begin
            // An oversize beat that is itself the tlast ends the packet here.
            if (too_big & ~s_axis_tlast) in_next = IN_DROP;
        end else begin
            if (in_hs & s_axis_tlast) in_next = IN_ACCEPT;
        end
    end

    always_ff @(posedge CORE_CLK) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    // out_q is the registered memory read port with a read enable, so it holds
    // the presented byte through a stall. The next byte is read on the same
    // edge as the handshake, which gives back-to-back bytes with no skid.
    assign out_hs   = (out_state == OUT_STREAM) & m_axis_tready;
    assign out_last = out_hs & out_q[8];

    always_comb begin
        out_next = out_state;
        rd_en    = 1'b0;
        unique case (out_state)
            OUT_IDLE: begin
                if (pkt_count != '0) out_next = OUT_LOAD;
            end
            OUT_LOAD: begin
                rd_en    = 1'b1;
                out_next = OUT_STREAM;
            end
            OUT_STREAM: begin
                if (out_hs) begin
                    if (!out_q[8]) begin
                        rd_en = 1'b1;
                    end else if (pkt_count > PW'(1)) begin
                        rd_en = 1'b1;
                    end else if (commit) begin
                        out_next = OUT_LOAD;
                    end else begin
                        out_next = OUT_IDLE;
                    end
                end
            end
            default: out_next = OUT_IDLE;
        endcase
        // rd_ptr never passes the committed boundary.
        if (rd_ptr == pkt_start) rd_en = 1'b0;
        if (flush) begin
            out_next = OUT_IDLE;
            rd_en    = 1'b0;
        end
    end

    assign m_axis_tvalid = (out_state == OUT_STREAM);
    assign m_axis_tdata  = out_q[7:0];
    assign m_axis_tlast  = out_q[8];

    // ------------------------------------------------------------------
    // State, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge CORE_CLK or negedge CORE_RSTN) begin
        if (!CORE_RSTN) begin
            in_state   <= IN_ACCEPT;
            out_state  <= OUT_IDLE;
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_start  <= '0;
            cur_len    <= '0;
            level      <= '0;
            pkt_count  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            out_q      <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            ready_en  <= 1'b1;

            if (rd_en) out_q <= mem[rd_ptr[AW-1:0]];

            if (too_big) begin
                overflow <= 1'b1;
                if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
            end

            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                pkt_start <= '0;
                cur_len   <= '0;
                level     <= '0;
                pkt_count <= '0;
            end else begin
                if (too_big) begin
                    wr_ptr  <= pkt_start;
                    cur_len <= '0;
                end else if (commit) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    pkt_start <= wr_ptr + 1'b1;
                    cur_len   <= '0;
                end else if (wr_en) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    cur_len <= cur_len + 1'b1;
                end

                if (rd_en) rd_ptr <= rd_ptr + 1'b1;

                level <= level + (AW+1)'(wr_en) - (AW+1)'(out_hs)
                               - (too_big ? cur_len : '0);
                pkt_count <= pkt_count + PW'(commit) - PW'(out_last);
            end
        end
    end

endmodule

// File: tb/tb_bcrypt_axis8_outpkt_fifo.sv
module tb_bcrypt_axis8_outpkt_fifo;

    localparam int DEPTH    = 16;
    localparam int MAX_PKTS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] s_data;
    logic       s_valid, s_ready, s_last;
    logic [7:0] m_data;
    logic       m_valid, m_ready, m_last;
    logic [4:0] pkt_count;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    bcrypt_axis8_outpkt_fifo #(.DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS)) dut (
        .CORE_CLK      (clk),
        .CORE_RSTN     (rst_n),
        .flush         (flush),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .pkt_count     (pkt_count),
        .level         (level),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: committed bytes awaiting output, the packet being
    // received, a discard flag and the number of dropped packets.
    logic [8:0] exp_q[$];
    logic [8:0] cur_q[$];
    bit         dropping;
    int         dropped;

    bit         last_in_hs, last_out_hs;
    bit         prev_stall;
    logic [8:0] prev_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_in(input logic [8:0] w);
        if (dropping) begin
            if (w[8]) dropping = 1'b0;
        end else begin
            cur_q.push_back(w);
            if (cur_q.size() > DEPTH) begin
                dropped++;
                cur_q.delete();
                if (!w[8]) dropping = 1'b1;
            end else if (w[8]) begin
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                cur_q.delete();
            end
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        if (cur_q.size() != 0) dropping = 1'b1;
        cur_q.delete();
    endtask

    // One clock cycle, entered and left at a falling edge. DUT state is
    // compared with the model, then this cycle's handshakes are recorded.
    task automatic tick();
        int np;
        logic [8:0] w;
        #1;
        if (rst_n) begin
            np = 0;
            foreach (exp_q[i]) if (exp_q[i][8]) np++;
            chk("level", 32'(level), exp_q.size() + cur_q.size());
            chk("pkt_count", 32'(pkt_count), np);
            chk("overflow", 32'(overflow), 32'(dropped > 0));
            chk("drop_count", 32'(drop_count), (dropped > 255) ? 255 : dropped);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_word", 32'({m_last, m_data}), 32'(prev_word));
            end
            last_in_hs  = s_valid & s_ready;
            last_out_hs = m_valid & m_ready & !flush;
            if (last_out_hs) begin
                chk("out_has_committed", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("out_word", 32'({m_last, m_data}), 32'(w));
                end
            end
            if (last_in_hs) model_in({s_last, s_data});
            if (flush) model_flush();
            prev_stall = m_valid & !m_ready & !flush;
            prev_word  = {m_last, m_data};
        end else begin
            last_in_hs  = 1'b0;
            last_out_hs = 1'b0;
            prev_stall  = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            tick();
            n++;
        end while (!last_in_hs && n < 300);
        chk("send_timeout", 32'(last_in_hs), 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        chk("valid_timeout", 32'(m_valid), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        exp_q.delete();
        cur_q.delete();
        dropping   = 1'b0;
        dropped    = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(s_ready), 0);
        @(negedge clk);
        chk("ready_after_edge", 32'(s_ready), 1);
    endtask

    initial begin
        int seen;
        int plen, pidx, pkts_left, n;

        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        do_reset();

        // 1: five-byte packet, latency and back-to-back delivery
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), i == 4);
        chk("t1_pkt_count", 32'(pkt_count), 1);
        chk("t1_valid_lat0", 32'(m_valid), 0);
        tick();
        chk("t1_valid_lat1", 32'(m_valid), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t1_consecutive", 32'(m_valid), 1);
            tick();
        end
        chk("t1_pkt_after", 32'(pkt_count), 0);
        chk("t1_level_after", 32'(level), 0);

        // 2: incomplete packet is held back
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_valid) seen++;
            tick();
        end
        chk("t2_no_valid", seen, 0);
        chk("t2_level", 32'(level), 3);
        send_byte(8'h04, 1'b1);
        drain();

        // 3: oversize packet dropped, following packet intact
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), i == 19);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_drop_count", 32'(drop_count), 1);
        chk("t3_level", 32'(level), 0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        drain();

        // 4: packet-count limit and release by one output handshake
        m_ready = 1'b0;
        for (int i = 0; i < MAX_PKTS; i++) send_byte(8'($urandom), 1'b1);
        chk("t4_pkt_full", 32'(pkt_count), 16);
        chk("t4_ready_low", 32'(s_ready), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t4_ready_back", 32'(s_ready), 1);
        drain();

        // 5: commit coinciding with an output tlast handshake
        m_ready = 1'b0;
        send_byte(8'hA0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b0);
        wait_valid();
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        chk("t5_last_shown", 32'({m_last, m_data}), 32'(9'h1A2));
        m_ready = 1'b1;
        send_byte(8'hB2, 1'b1);
        m_ready = 1'b0;
        chk("t5_pkt_same", 32'(pkt_count), 1);
        drain();

        // 6a: random traffic with random back-pressure and some oversize packets
        plen = 0;
        pidx = 0;
        pkts_left = 40;
        n = 0;
        while ((pkts_left > 0 || s_valid) && n < 6000) begin
            if (!s_valid && pkts_left > 0 && $urandom_range(0, 3) != 0) begin
                if (plen == 0) begin
                    plen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 19))
                                                        : int'($urandom_range(1, 12));
                    pidx = 0;
                end
                s_valid = 1'b1;
                s_data  = 8'($urandom);
                s_last  = (pidx == plen - 1);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_in_hs) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                pidx++;
                if (pidx == plen) begin
                    plen = 0;
                    pkts_left--;
                end
            end
            n++;
        end
        chk("t6_traffic_done", pkts_left, 0);
        drain();

        // 6b: flush while a packet streams and another is half received
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), i == 5);
        wait_valid();
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        send_byte(8'h50, 1'b0);
        send_byte(8'h51, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_tvalid", 32'(m_valid), 0);
        chk("flush_level", 32'(level), 0);
        chk("flush_overflow_kept", 32'(overflow), 32'(dropped > 0));
        chk("flush_drops_kept", 32'(drop_count > 0), 1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h60, 1'b0);
        send_byte(8'h61, 1'b1);
        drain();

        // 7: asynchronous reset in the middle of a packet
        m_ready = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        do_reset();
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b1);
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
